cursor_engine: RTL and testbench

Parametrised cursor-position engine for the virtual-console parser. Accepts one decoded command per handshake and maintains the absolute cursor, a per-column tab-stop map, a DECSC/DECRC save slot and a DEC-style deferred-wrap flag. Issues scroll requests to the text-buffer scroller over a valid/ready handshake and stalls further commands until the request is taken. Sits between the escape-sequence decoder and the render/scroll logic.

---
 rtl/cursor_engine_if.sv | 41 ++++
 rtl/cursor_engine.sv | 212 +++++++++++++++++++++
 tb/tb_cursor_engine.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cursor_engine_if.sv
// rtl/cursor_engine_if.sv - command, cursor and scroll-request bundle for cursor_engine
// Ports:
//   master: decoder/scroller side; drives commands, mode bits, margins and scroll_ready
//   slave : cursor_engine side; drives cmd_ready, cursor state and the scroll request
interface cursor_engine_if #(
  parameter int W = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [4:0]   cmd_op;
  logic [W-1:0] cmd_p1;
  logic [W-1:0] cmd_p2;
  logic         origin_mode;
  logic         auto_wrap;
  logic         lf_newline;
  logic [W-1:0] scroll_top;
  logic [W-1:0] scroll_bottom;
  logic [W-1:0] cur_row;
  logic [W-1:0] cur_col;
  logic         wrap_pending;
  logic         scroll_valid;
  logic         scroll_ready;
  logic         scroll_dir;
  logic [W-1:0] scroll_step;
  logic [W-1:0] scroll_lo;
  logic [W-1:0] scroll_hi;

  modport master (
    output cmd_valid, cmd_op, cmd_p1, cmd_p2, origin_mode, auto_wrap, lf_newline,
           scroll_top, scroll_bottom, scroll_ready,
    input  cmd_ready, cur_row, cur_col, wrap_pending, scroll_valid, scroll_dir,
           scroll_step, scroll_lo, scroll_hi
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_p1, cmd_p2, origin_mode, auto_wrap, lf_newline,
           scroll_top, scroll_bottom, scroll_ready,
    output cmd_ready, cur_row, cur_col, wrap_pending, scroll_valid, scroll_dir,
           scroll_step, scroll_lo, scroll_hi
  );
endinterface

// File: rtl/cursor_engine.sv
// rtl/cursor_engine.sv - console cursor engine: position, tab stops, save slot, deferred wrap, scroll requests
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : cursor_engine_if slave (command handshake, mode bits, margins,
//           cursor outputs, scroll request handshake)
module cursor_engine #(
  parameter int COLS  = 80,
  parameter int LINES = 30,
  parameter int W     = 8,
  parameter int TAB   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  cursor_engine_if.slave  bus
);
  typedef logic [W:0]   wide_t;
  typedef logic [W-1:0] coord_t;
  typedef enum logic [1:0] {IDLE, TAB_SCAN, SCROLL_WAIT} state_t;

  localparam int     CW       = (COLS > 1) ? $clog2(COLS) : 1;
  localparam wide_t  COL_MAX  = wide_t'(COLS - 1);
  localparam wide_t  ROW_MAX  = wide_t'(LINES - 1);
  localparam coord_t COL_LAST = coord_t'(COLS - 1);

  localparam logic [4:0] OP_CUP = 5'd0,  OP_CUF = 5'd1,  OP_CUB = 5'd2,  OP_CUD = 5'd3,
                         OP_CUU = 5'd4,  OP_CHA = 5'd5,  OP_VPA = 5'd6,  OP_IND = 5'd7,
                         OP_RI  = 5'd8,  OP_NEL = 5'd9,  OP_HTS = 5'd10, OP_TBC = 5'd11,
                         OP_CHT = 5'd12, OP_CBT = 5'd13, OP_DECSC = 5'd14, OP_DECRC = 5'd15,
                         OP_DECSTBM = 5'd16, OP_PRINT = 5'd17, OP_LF = 5'd18, OP_CR = 5'd19,
                         OP_BS = 5'd20, OP_HT = 5'd21;

  function automatic wide_t wmin(input wide_t a, input wide_t b);
    return (a < b) ? a : b;
  endfunction

  state_t          state;
  coord_t          row_q, col_q, sv_row, sv_col, tab_cnt;
  logic            wrap_q, sv_wrap, tab_back;
  logic [COLS-1:0] tabs;
  logic            sc_valid, sc_dir;
  coord_t          sc_step, sc_lo, sc_hi;

  logic   accept, at_bot, at_top, in_margin, ind_op, raise_up, raise_dn, tab_hit;
  wide_t  row_w, col_w, top_w, bot_w, pn, pl, pc, org, rmax, vlo, vhi, cup_row;
  coord_t ind_row, nxt_col;

  assign bus.cmd_ready    = (state == IDLE) && !sc_valid;
  assign bus.cur_row      = row_q;
  assign bus.cur_col      = col_q;
  assign bus.wrap_pending = wrap_q;
  assign bus.scroll_valid = sc_valid;
  assign bus.scroll_dir   = sc_dir;
  assign bus.scroll_step  = sc_step;
  assign bus.scroll_lo    = sc_lo;
  assign bus.scroll_hi    = sc_hi;

  assign accept = bus.cmd_valid && bus.cmd_ready;

  // All arithmetic is one bit wider than the coordinates so sums saturate instead of wrapping.
  assign row_w = {1'b0, row_q};
  assign col_w = {1'b0, col_q};
  assign top_w = {1'b0, bus.scroll_top};
  assign bot_w = {1'b0, bus.scroll_bottom};
  assign pn    = {1'b0, (bus.cmd_p1 != '0) ? bus.cmd_p1 : coord_t'(1)};
  assign pl    = (bus.cmd_p1 != '0) ? {1'b0, bus.cmd_p1 - 1'b1} : '0;
  assign pc    = (bus.cmd_p2 != '0) ? {1'b0, bus.cmd_p2 - 1'b1} : '0;
  assign org   = bus.origin_mode ? top_w : '0;
  assign rmax  = bus.origin_mode ? bot_w : ROW_MAX;
  assign cup_row = wmin(org + pl, rmax);

  // Vertical relative moves are confined to the margins only while the cursor is inside them.
  assign in_margin = (row_q >= bus.scroll_top) && (row_q <= bus.scroll_bottom);
  assign vlo       = in_margin ? top_w : '0;
  assign vhi       = in_margin ? bot_w : ROW_MAX;

  assign at_bot  = (row_q == bus.scroll_bottom);
  assign at_top  = (row_q == bus.scroll_top);
  assign ind_row = at_bot ? row_q : coord_t'(wmin(row_w + 1'b1, ROW_MAX));

  // A wrapped PRINT performs an implicit index, so it can scroll too.
  assign ind_op   = (bus.cmd_op == OP_IND) || (bus.cmd_op == OP_LF) || (bus.cmd_op == OP_NEL) ||
                    ((bus.cmd_op == OP_PRINT) && wrap_q && bus.auto_wrap);
  assign raise_up = ind_op && at_bot;
  assign raise_dn = (bus.cmd_op == OP_RI) && at_top;

  assign nxt_col = tab_back ? col_q - 1'b1 : col_q + 1'b1;
  assign tab_hit = tabs[CW'(nxt_col)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      wrap_q   <= 1'b0;
      sv_row   <= '0;
      sv_col   <= '0;
      sv_wrap  <= 1'b0;
      tab_cnt  <= '0;
      tab_back <= 1'b0;
      sc_valid <= 1'b0;
      sc_dir   <= 1'b0;
      sc_step  <= '0;
      sc_lo    <= '0;
      sc_hi    <= '0;
      for (int c = 0; c < COLS; c++) tabs[c] <= ((c % TAB) == 0) && (c != 0);
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.cmd_op != OP_PRINT && bus.cmd_op != OP_DECSC) wrap_q <= 1'b0;
            case (bus.cmd_op)
              OP_CUP: begin
                row_q <= coord_t'(cup_row);
                col_q <= coord_t'(wmin(pc, COL_MAX));
              end
              OP_CUF: col_q <= coord_t'(wmin(col_w + pn, COL_MAX));
              OP_CUB: col_q <= (col_w < pn) ? '0 : coord_t'(col_w - pn);
              OP_CUD: row_q <= coord_t'(wmin(row_w + pn, vhi));
              OP_CUU: row_q <= (row_w < vlo + pn) ? coord_t'(vlo) : coord_t'(row_w - pn);
              OP_CHA: col_q <= coord_t'(wmin(pl, COL_MAX));
              OP_VPA: row_q <= coord_t'(cup_row);
              OP_IND: row_q <= ind_row;
              OP_RI:  if (!at_top) row_q <= (row_q == '0) ? '0 : row_q - 1'b1;
              OP_NEL: begin
                row_q <= ind_row;
                col_q <= '0;
              end
              OP_LF: begin
                row_q <= ind_row;
                if (bus.lf_newline) col_q <= '0;
              end
              OP_HTS: tabs[CW'(col_q)] <= 1'b1;
              OP_TBC: begin
                if (bus.cmd_p1 == coord_t'(0))      tabs[CW'(col_q)] <= 1'b0;
                else if (bus.cmd_p1 == coord_t'(3)) tabs <= '0;
              end
              OP_HT: begin
                tab_back <= 1'b0;
                tab_cnt  <= coord_t'(1);
                state    <= TAB_SCAN;
              end
              OP_CHT: begin
                tab_back <= 1'b0;
                tab_cnt  <= coord_t'(pn);
                state    <= TAB_SCAN;
              end
              OP_CBT: begin
                tab_back <= 1'b1;
                tab_cnt  <= coord_t'(pn);
                state    <= TAB_SCAN;
              end
              OP_DECSC: begin
                sv_row  <= row_q;
                sv_col  <= col_q;
                sv_wrap <= wrap_q;
              end
              OP_DECRC: begin
                row_q  <= sv_row;
                col_q  <= sv_col;
                wrap_q <= sv_wrap;
              end
              // New margins only show up on scroll_top next cycle, so the home row comes from p1.
              OP_DECSTBM: begin
                row_q <= bus.origin_mode ? coord_t'(wmin(pl, ROW_MAX)) : '0;
                col_q <= '0;
              end
              OP_PRINT: begin
                if (wrap_q && bus.auto_wrap) begin
                  col_q  <= coord_t'(1);
                  row_q  <= ind_row;
                  wrap_q <= 1'b0;
                end else if (col_q < COL_LAST) begin
                  col_q <= col_q + 1'b1;
                end else if (bus.auto_wrap) begin
                  wrap_q <= 1'b1;
                end
              end
              OP_CR: col_q <= '0;
              OP_BS: if (col_q != '0) col_q <= col_q - 1'b1;
              default: ;
            endcase
            if (raise_up || raise_dn) begin
              sc_valid <= 1'b1;
              sc_dir   <= raise_dn;
              sc_step  <= coord_t'(1);
              sc_lo    <= bus.scroll_top;
              sc_hi    <= bus.scroll_bottom;
              state    <= SCROLL_WAIT;
            end
          end
        end
        // One column per cycle; the cycle that sees the stop condition returns to IDLE.
        TAB_SCAN: begin
          if (tab_cnt == '0 || (tab_back ? (col_q == '0) : (col_q == COL_LAST))) begin
            state <= IDLE;
          end else begin
            col_q <= nxt_col;
            if (tab_hit) tab_cnt <= tab_cnt - 1'b1;
          end
        end
        SCROLL_WAIT: begin
          if (bus.scroll_ready) begin
            sc_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cursor_engine.sv
// tb/tb_cursor_engine.sv - directed self-checking bench for cursor_engine
module tb_cursor_engine;
  localparam logic [4:0] OP_CUP = 5'd0, OP_CUB = 5'd2, OP_CUD = 5'd3, OP_CUU = 5'd4,
                         OP_VPA = 5'd6, OP_RI = 5'd8, OP_HTS = 5'd10, OP_TBC = 5'd11,
                         OP_CHT = 5'd12, OP_CBT = 5'd13, OP_DECSC = 5'd14, OP_DECRC = 5'd15,
                         OP_PRINT = 5'd17, OP_LF = 5'd18, OP_CR = 5'd19, OP_HT = 5'd21;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cursor_engine_if #(.W(8)) bus();

  cursor_engine #(.COLS(80), .LINES(30), .W(8), .TAB(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  // Returns at the falling edge right after the accepting clock edge.
  task automatic send(input logic [4:0] op, input logic [7:0] p1, input logic [7:0] p2);
    @(negedge clk);
    wait_idle("send_ready");
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_p1    = p1;
    bus.cmd_p2    = p2;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    bus.cmd_valid     = 1'b0;
    bus.cmd_op        = '0;
    bus.cmd_p1        = '0;
    bus.cmd_p2        = '0;
    bus.origin_mode   = 1'b0;
    bus.auto_wrap     = 1'b0;
    bus.lf_newline    = 1'b0;
    bus.scroll_top    = 8'd0;
    bus.scroll_bottom = 8'd29;
    bus.scroll_ready  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_row", bus.cur_row, 0);
    chk("rst_col", bus.cur_col, 0);
    chk("rst_wrap", bus.wrap_pending, 0);
    chk("rst_svalid", bus.scroll_valid, 0);
    chk("rst_shi", bus.scroll_hi, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    rst_n = 1'b1;

    send(OP_CUP, 8'd5, 8'd10);
    chk("cup_row", bus.cur_row, 4);
    chk("cup_col", bus.cur_col, 9);
    send(OP_CUP, 8'd200, 8'd200);
    chk("cup_clamp_row", bus.cur_row, 29);
    chk("cup_clamp_col", bus.cur_col, 79);
    send(OP_CUB, 8'd100, 8'd0);
    chk("cub_floor", bus.cur_col, 0);

    // Index at the bottom margin with the scroller stalled for three cycles.
    bus.scroll_top    = 8'd5;
    bus.scroll_bottom = 8'd20;
    send(OP_CUP, 8'd21, 8'd1);
    chk("cup21_row", bus.cur_row, 20);
    send(OP_LF, 8'd0, 8'd0);
    chk("lf_dir", bus.scroll_dir, 0);
    chk("lf_lo", bus.scroll_lo, 5);
    chk("lf_hi", bus.scroll_hi, 20);
    chk("lf_step", bus.scroll_step, 1);
    for (int i = 0; i < 4; i++) begin
      chk("lf_svalid_hold", bus.scroll_valid, 1);
      chk("lf_ready_low", bus.cmd_ready, 0);
      chk("lf_row_kept", bus.cur_row, 20);
      if (i == 3) bus.scroll_ready = 1'b1;
      @(negedge clk);
    end
    chk("lf_svalid_drop", bus.scroll_valid, 0);
    chk("lf_ready_back", bus.cmd_ready, 1);
    bus.scroll_ready  = 1'b0;
    bus.scroll_top    = 8'd0;
    bus.scroll_bottom = 8'd29;

    // Deferred wrap.
    bus.auto_wrap = 1'b1;
    send(OP_CUP, 8'd3, 8'd80);
    send(OP_PRINT, 8'd0, 8'd0);
    chk("pr1_col", bus.cur_col, 79);
    chk("pr1_wrap", bus.wrap_pending, 1);
    send(OP_PRINT, 8'd0, 8'd0);
    chk("pr2_row", bus.cur_row, 3);
    chk("pr2_col", bus.cur_col, 1);
    chk("pr2_wrap", bus.wrap_pending, 0);
    bus.auto_wrap = 1'b0;
    send(OP_CUP, 8'd3, 8'd80);
    send(OP_PRINT, 8'd0, 8'd0);
    chk("pr_nowrap_col", bus.cur_col, 79);
    chk("pr_nowrap_flag", bus.wrap_pending, 0);

    // Tab stops: HT from column 3 lands on 8 after six cycles, idle on the seventh.
    send(OP_CUP, 8'd1, 8'd4);
    chk("ht_start", bus.cur_col, 3);
    send(OP_HT, 8'd0, 8'd0);
    repeat (5) @(negedge clk);
    chk("ht_col", bus.cur_col, 8);
    chk("ht_busy", bus.cmd_ready, 0);
    @(negedge clk);
    chk("ht_done", bus.cmd_ready, 1);
    send(OP_CUP, 8'd1, 8'd1);
    send(OP_CHT, 8'd3, 8'd0);
    wait_idle("cht_idle");
    chk("cht_col", bus.cur_col, 24);
    send(OP_CBT, 8'd0, 8'd0);
    wait_idle("cbt_idle");
    chk("cbt_col", bus.cur_col, 16);
    send(OP_CUP, 8'd1, 8'd11);
    send(OP_HTS, 8'd0, 8'd0);
    send(OP_CUP, 8'd1, 8'd1);
    send(OP_HT, 8'd0, 8'd0);
    wait_idle("hts_idle");
    chk("hts_col", bus.cur_col, 8);
    send(OP_HT, 8'd0, 8'd0);
    wait_idle("hts_idle2");
    chk("hts_col2", bus.cur_col, 10);
    send(OP_TBC, 8'd3, 8'd0);
    send(OP_CUP, 8'd1, 8'd1);
    send(OP_HT, 8'd0, 8'd0);
    wait_idle("tbc_idle");
    chk("tbc_col", bus.cur_col, 79);

    // Origin mode.
    bus.origin_mode   = 1'b1;
    bus.scroll_top    = 8'd10;
    bus.scroll_bottom = 8'd15;
    send(OP_CUP, 8'd9, 8'd0);
    chk("org_cup_row", bus.cur_row, 15);
    send(OP_VPA, 8'd1, 8'd0);
    chk("org_vpa_row", bus.cur_row, 10);
    send(OP_CUU, 8'd50, 8'd0);
    chk("org_cuu_row", bus.cur_row, 10);
    send(OP_CUD, 8'd50, 8'd0);
    chk("org_cud_row", bus.cur_row, 15);
    bus.origin_mode   = 1'b0;
    bus.scroll_top    = 8'd0;
    bus.scroll_bottom = 8'd29;

    // Save / restore.
    send(OP_CUP, 8'd8, 8'd34);
    send(OP_DECSC, 8'd0, 8'd0);
    send(OP_CUP, 8'd1, 8'd1);
    chk("sc_moved", bus.cur_col, 0);
    send(OP_DECRC, 8'd0, 8'd0);
    chk("rc_row", bus.cur_row, 7);
    chk("rc_col", bus.cur_col, 33);
    chk("rc_wrap", bus.wrap_pending, 0);
    bus.auto_wrap = 1'b1;
    send(OP_CUP, 8'd8, 8'd80);
    send(OP_PRINT, 8'd0, 8'd0);
    send(OP_DECSC, 8'd0, 8'd0);
    chk("sc_keeps_wrap", bus.wrap_pending, 1);
    send(OP_CR, 8'd0, 8'd0);
    chk("cr_clears_wrap", bus.wrap_pending, 0);
    send(OP_DECRC, 8'd0, 8'd0);
    chk("rc2_col", bus.cur_col, 79);
    chk("rc2_wrap", bus.wrap_pending, 1);
    bus.auto_wrap = 1'b0;

    // Reverse index at the top margin requests a downward scroll.
    send(OP_CUP, 8'd1, 8'd1);
    send(OP_RI, 8'd0, 8'd0);
    chk("ri_svalid", bus.scroll_valid, 1);
    chk("ri_dir", bus.scroll_dir, 1);
    chk("ri_row", bus.cur_row, 0);
    bus.scroll_ready = 1'b1;
    @(negedge clk);
    chk("ri_drop", bus.scroll_valid, 0);
    bus.scroll_ready = 1'b0;

    // Reset while a scroll request is pending.
    send(OP_CUP, 8'd30, 8'd5);
    send(OP_LF, 8'd0, 8'd0);
    chk("lf2_svalid", bus.scroll_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_svalid", bus.scroll_valid, 0);
    chk("arst_row", bus.cur_row, 0);
    chk("arst_col", bus.cur_col, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_svalid", bus.scroll_valid, 0);
    chk("post_rst_ready", bus.cmd_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
